// File: rtl/fifo_read_streamer.sv
// fifo_read_streamer: FIFO read-port controller; absorbs read latency in a skid buffer, streams valid/ready, supports flush.
// Optional sticky ERR output is enabled by defining FIFO_READ_STREAMER_ERR_EN.
module fifo_read_streamer #(
  parameter int DATA_WIDTH   = 36,
  parameter int READ_LATENCY = 1,
  parameter int BUF_DEPTH    = READ_LATENCY + 2
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic                  FIFO_EMPTY,
  input  logic                  FIFO_ALMOST_EMPTY,
  input  logic                  FIFO_UNDERFLOW,
  input  logic [DATA_WIDTH-1:0] FIFO_RD_DATA,
  output logic                  FIFO_RD_EN,
  output logic [DATA_WIDTH-1:0] M_DATA,
  output logic                  M_VALID,
  input  logic                  M_READY,
  input  logic                  FLUSH,
  output logic                  BUSY
`ifdef FIFO_READ_STREAMER_ERR_EN
  ,
  output logic                  ERR
`endif
);
  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(BUF_DEPTH);
  typedef enum logic {ST_STREAM, ST_FLUSH} state_t;
  state_t state_q, state_d;
  logic rd_en_q, rd_en_d;
  logic [READ_LATENCY-1:0] pipe_q, pipe_d;
  logic [CW-1:0] occ_q, occ_d, in_flight_q, in_flight_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DATA_WIDTH-1:0] buf_q [BUF_DEPTH];
  logic [DATA_WIDTH-1:0] buf_d [BUF_DEPTH];
  logic flushing, start_flush, capture, keep, pop, done;
  logic [CW:0] used;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // in_flight counts the read issued this cycle plus those still in the latency pipe
  always_comb begin
    flushing    = state_q == ST_FLUSH;
    start_flush = FLUSH && !flushing;
    capture     = pipe_q[READ_LATENCY-1];
    keep        = capture && !flushing && !start_flush;
    pop         = M_VALID && M_READY;
    used        = {1'b0, occ_q} + {1'b0, in_flight_q} - {{CW{1'b0}}, pop};
    rd_en_d     = !FIFO_EMPTY && !(FIFO_ALMOST_EMPTY && rd_en_q) && (flushing || used < DEPTH_W);
    pipe_d      = (pipe_q << 1) | READ_LATENCY'(rd_en_q);
    in_flight_d = in_flight_q + CW'(rd_en_d) - CW'(capture);
    occ_d       = start_flush ? '0 : occ_q + CW'(keep) - CW'(pop);
    wr_ptr_d    = start_flush ? '0 : keep ? nxt(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d    = start_flush ? '0 : pop ? nxt(rd_ptr_q) : rd_ptr_q;
    buf_d       = buf_q;
    if (keep) buf_d[wr_ptr_q] = FIFO_RD_DATA;
    done        = flushing && FIFO_EMPTY && in_flight_q == '0 && !rd_en_d;
    state_d     = start_flush ? ST_FLUSH : (done ? ST_STREAM : state_q);
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= ST_STREAM;
      rd_en_q     <= 1'b0;
      pipe_q      <= '0;
      occ_q       <= '0;
      in_flight_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      buf_q       <= '{default: '0};
    end else begin
      state_q     <= state_d;
      rd_en_q     <= rd_en_d;
      pipe_q      <= pipe_d;
      occ_q       <= occ_d;
      in_flight_q <= in_flight_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      buf_q       <= buf_d;
    end
  end

  assign FIFO_RD_EN = rd_en_q;
  assign M_VALID    = occ_q != '0;
  assign M_DATA     = buf_q[rd_ptr_q];
  assign BUSY       = flushing;

`ifdef FIFO_READ_STREAMER_ERR_EN
  logic err_q, err_d;
  always_comb err_d = (err_q && !done) || FIFO_UNDERFLOW || (rd_en_q && FIFO_EMPTY);
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) err_q <= 1'b0;
    else          err_q <= err_d;
  end
  assign ERR = err_q;
`else
  logic unused_underflow;
  assign unused_underflow = FIFO_UNDERFLOW;
`endif
endmodule

// File: tb/tb_fifo_read_streamer.sv
// tb_fifo_read_streamer: directed + randomized bench with a queue-based FIFO and stream scoreboard.
module tb_fifo_read_streamer;
  localparam int DW = 36;
  localparam int RL = 1;
  localparam int BD = RL + 2;

  logic CLK = 1'b0, RESET_N = 1'b0;
  logic FIFO_EMPTY, FIFO_ALMOST_EMPTY, FIFO_UNDERFLOW, FIFO_RD_EN;
  logic M_VALID, M_READY = 1'b0, FLUSH = 1'b0, BUSY;
  logic [DW-1:0] FIFO_RD_DATA = '0, M_DATA;
`ifdef FIFO_READ_STREAMER_ERR_EN
  logic ERR;
`endif

  fifo_read_streamer #(.DATA_WIDTH(DW), .READ_LATENCY(RL), .BUF_DEPTH(BD)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .FIFO_EMPTY(FIFO_EMPTY), .FIFO_ALMOST_EMPTY(FIFO_ALMOST_EMPTY),
    .FIFO_UNDERFLOW(FIFO_UNDERFLOW), .FIFO_RD_DATA(FIFO_RD_DATA), .FIFO_RD_EN(FIFO_RD_EN),
    .M_DATA(M_DATA), .M_VALID(M_VALID), .M_READY(M_READY), .FLUSH(FLUSH), .BUSY(BUSY)
`ifdef FIFO_READ_STREAMER_ERR_EN
    , .ERR(ERR)
`endif
  );

  always #5 CLK = ~CLK;

  // FIFO model: word storage indexed by write/read counts, flags derived from the fill level
  logic [DW-1:0] mem [4096];
  int wr_idx = 0, rd_idx = 0, rd_cnt = 0;
  logic uf_q = 1'b0, uf_force = 1'b0;
  assign FIFO_EMPTY        = (wr_idx == rd_idx);
  assign FIFO_ALMOST_EMPTY = (wr_idx - rd_idx) <= 1;
  assign FIFO_UNDERFLOW    = uf_q | uf_force;
  always @(posedge CLK) begin
    if (FIFO_RD_EN && !FIFO_EMPTY) begin
      FIFO_RD_DATA <= mem[rd_idx % 4096];
      rd_idx       <= rd_idx + 1;
    end
    if (FIFO_RD_EN) rd_cnt <= rd_cnt + 1;
    uf_q <= FIFO_RD_EN && FIFO_EMPTY;
  end

  logic [DW-1:0] exp_q[$];
  int n_checks = 0, n_fail = 0, cyc_n = 0, tx = 0;
  int first_rd = -1, first_v = -1, last_v = -1, nvalid = 0;
  logic prev_hold = 1'b0;
  logic [DW-1:0] prev_data = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [DW-1:0] d);
    mem[wr_idx % 4096] = d;
    wr_idx++;
    exp_q.push_back(d);
  endtask

  task automatic check();
    logic [DW-1:0] d;
    if (RESET_N) begin
      if (prev_hold) begin
        chk("hold_valid", 64'(M_VALID), 64'd1);
        chk("hold_data", 64'(M_DATA), 64'(prev_data));
      end
      chk("busy_valid", 64'(BUSY && M_VALID), 64'd0);
      chk("rd_on_empty", 64'(FIFO_RD_EN && FIFO_EMPTY), 64'd0);
      if (FIFO_RD_EN && first_rd < 0) first_rd = cyc_n;
      if (M_VALID) begin
        if (first_v < 0) first_v = cyc_n;
        last_v = cyc_n;
        nvalid++;
      end
      if (M_VALID && M_READY) begin
        chk("spurious_word", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          d = exp_q.pop_front();
          chk("data", 64'(M_DATA), 64'(d));
        end
        tx++;
      end
      prev_hold = M_VALID && !M_READY && !FLUSH;
      prev_data = M_DATA;
    end else prev_hold = 1'b0;
  endtask

  task automatic cyc();
    @(negedge CLK);
    check();
    @(posedge CLK);
    #1;
    cyc_n++;
  endtask

  task automatic drain(input string tag, input int bound);
    int n = 0;
    M_READY = 1'b1;
    while (exp_q.size() != 0 && n < bound) begin
      cyc();
      n++;
    end
    chk(tag, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic wait_idle(input string tag, input int bound);
    int n = 0;
    while (BUSY && n < bound) begin
      cyc();
      n++;
    end
    chk(tag, 64'(BUSY), 64'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int t0, x0, n;
    repeat (3) cyc();
    chk("reset_rd_en", 64'(FIFO_RD_EN), 64'd0);
    chk("reset_valid", 64'(M_VALID), 64'd0);
    chk("reset_data", 64'(M_DATA), 64'd0);
    chk("reset_busy", 64'(BUSY), 64'd0);
`ifdef FIFO_READ_STREAMER_ERR_EN
    chk("reset_err", 64'(ERR), 64'd0);
`endif
    RESET_N = 1'b1;
    cyc();

    // 1: eight pre-loaded words stream back-to-back
    M_READY = 1'b1;
    first_rd = -1; first_v = -1; last_v = -1; nvalid = 0;
    for (int i = 1; i <= 8; i++) push(DW'(i));
    repeat (20) cyc();
    chk("t1_latency", 64'(first_v - first_rd), 64'd2);
    chk("t1_nvalid", 64'(nvalid), 64'd8);
    chk("t1_consecutive", 64'(last_v - first_v), 64'd7);
    chk("t1_drained", 64'(exp_q.size()), 64'd0);
    chk("t1_underflow", 64'(FIFO_UNDERFLOW), 64'd0);

    // 2: backpressure fills exactly the skid buffer
    M_READY = 1'b0;
    t0 = rd_cnt; x0 = tx;
    for (int i = 1; i <= 8; i++) push(DW'(i));
    repeat (20) cyc();
    chk("t2_reads", 64'(rd_cnt - t0), 64'(BD));
    chk("t2_valid", 64'(M_VALID), 64'd1);
    chk("t2_head", 64'(M_DATA), 64'h1);
    drain("t2_drain", 50);
    chk("t2_count", 64'(tx - x0), 64'd8);

    // 3: single word, almost-empty must suppress the second read
    t0 = rd_cnt; x0 = tx;
    push(DW'({$urandom(), $urandom()}));
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("t3_underflow", 64'(FIFO_UNDERFLOW), 64'd0);
    end
    chk("t3_reads", 64'(rd_cnt - t0), 64'd1);
    chk("t3_transfers", 64'(tx - x0), 64'd1);

    // 4: flush after consuming three of twenty
    x0 = tx;
    for (int i = 0; i < 20; i++) push(DW'({$urandom(), $urandom()}));
    n = 0;
    while (tx - x0 < 3 && n < 50) begin cyc(); n++; end
    chk("t4_consumed", 64'(tx - x0), 64'd3);
    M_READY = 1'b0;
    FLUSH = 1'b1;
    exp_q.delete();
    cyc();
    FLUSH = 1'b0;
    M_READY = 1'b1;
    chk("t4_busy", 64'(BUSY), 64'd1);
    chk("t4_valid", 64'(M_VALID), 64'd0);
    wait_idle("t4_busy_fall", 300);
    chk("t4_fifo_empty", 64'(FIFO_EMPTY), 64'd1);
    x0 = tx;
    push(DW'(36'hA5));
    drain("t4_a5", 20);
    chk("t4_a5_count", 64'(tx - x0), 64'd1);

    // 5: asynchronous reset with reads in flight
    x0 = tx;
    for (int i = 0; i < 10; i++) push(DW'({$urandom(), $urandom()}));
    n = 0;
    while (tx - x0 < 1 && n < 20) begin cyc(); n++; end
    RESET_N = 1'b0;
    #1;
    chk("t5_rd_en", 64'(FIFO_RD_EN), 64'd0);
    chk("t5_valid", 64'(M_VALID), 64'd0);
    chk("t5_data", 64'(M_DATA), 64'd0);
    chk("t5_busy", 64'(BUSY), 64'd0);
    while (exp_q.size() > wr_idx - rd_idx) void'(exp_q.pop_front());
    cyc();
    RESET_N = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cyc();
      chk("t5_valid_after_release", 64'(M_VALID), 64'd0);
    end
    drain("t5_drain", 50);

    // random traffic with random backpressure
    for (int i = 0; i < 150; i++) begin
      M_READY = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 2) == 0) push(DW'({$urandom(), $urandom()}));
      cyc();
    end
    drain("rand_drain", 300);
    repeat (5) cyc();
    chk("rand_idle_valid", 64'(M_VALID), 64'd0);

`ifdef FIFO_READ_STREAMER_ERR_EN
    // 6: sticky ERR cleared by flush completion
    chk("t6_err_init", 64'(ERR), 64'd0);
    uf_force = 1'b1;
    cyc();
    uf_force = 1'b0;
    chk("t6_err_set", 64'(ERR), 64'd1);
    repeat (3) cyc();
    chk("t6_err_sticky", 64'(ERR), 64'd1);
    FLUSH = 1'b1;
    cyc();
    FLUSH = 1'b0;
    chk("t6_busy", 64'(BUSY), 64'd1);
    wait_idle("t6_busy_fall", 20);
    chk("t6_err_clear", 64'(ERR), 64'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
